// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard / stall controller for a classic 5-stage in-order pipeline.
// Handles three event classes seen from the ID stage:
//   * taken branch/jump resolved in EX  -> flush IF/ID, bubble ID/EX
//   * load-use hazard (EX load feeds ID) -> freeze PC and IF/ID, bubble ID/EX
//                                           for LU_STALL_CYCLES cycles total
//   * multiply/divide in ID              -> launch mul/div unit, hold the
//                                           front end until md_done or timeout
//
// Parameters
//   LU_STALL_CYCLES  total ID stall cycles per load-use hazard (1..4)
//   MD_TIMEOUT       max MD_BUSY stall cycles before aborting (1..255)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   RsAddr_id/RtAddr_id  ID source registers
//   MemRead_ex        EX instruction is a load
//   RegWriteAddr_ex   EX destination register
//   branch_taken_ex   EX resolved a taken branch/jump
//   md_req_id         ID instruction is mul/div
//   md_done           one-cycle completion pulse from mul/div
//   pc_write, ifid_write  PC / IF/ID enables
//   idex_bubble       load a NOP into ID/EX
//   ifid_flush        clear IF/ID
//   md_start          one-cycle launch pulse to mul/div
//   md_error          sticky mul/div timeout flag
//   stall_cnt         saturating count of cycles with pc_write low
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MD_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RsAddr_id,
  input  logic [4:0]  RtAddr_id,
  input  logic        MemRead_ex,
  input  logic [4:0]  RegWriteAddr_ex,
  input  logic        branch_taken_ex,
  input  logic        md_req_id,
  input  logic        md_done,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        md_start,
  output logic        md_error,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_BUSY  = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // A single-cycle load-use stall never leaves RUN; longer stalls spend the
  // remaining LU_STALL_CYCLES-1 cycles in LU_STALL counting down to zero.
  localparam bit         LU_MULTI = (LU_STALL_CYCLES > 1);
  localparam int         LU_LOAD_I = LU_MULTI ? int'(LU_STALL_CYCLES) - 2 : 0;
  localparam logic [1:0] LU_LOAD  = 2'(LU_LOAD_I);
  localparam logic [7:0] TO_LIMIT = 8'(MD_TIMEOUT);

  state_t      r_state;
  logic [1:0]  r_lu_cnt;
  logic [7:0]  r_to_cnt;
  logic        r_md_error;
  logic [15:0] r_stall_cnt;

  state_t      w_next;
  logic [1:0]  w_lu_cnt_nxt;
  logic [7:0]  w_to_cnt_nxt;
  logic        w_set_err;
  logic        w_lu;
  logic        w_stall;
  logic        w_flush;
  logic        w_start;

  assign w_lu = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                ((RegWriteAddr_ex == RsAddr_id) || (RegWriteAddr_ex == RtAddr_id));

  // Next-state and event decode. HOLD is unreachable and behaves as RUN.
  always_comb begin
    w_next       = RUN;
    w_lu_cnt_nxt = r_lu_cnt;
    w_to_cnt_nxt = r_to_cnt;
    w_set_err    = 1'b0;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      LU_STALL: begin
        w_stall = 1'b1;
        if (r_lu_cnt == 2'd0) begin
          w_next = RUN;
        end else begin
          w_next       = LU_STALL;
          w_lu_cnt_nxt = r_lu_cnt - 2'd1;
        end
      end
      MD_BUSY: begin
        if (md_done) begin
          w_next = RUN;
        end else if (r_to_cnt == TO_LIMIT) begin
          // Unit never answered: give up, release the front end, flag it.
          w_next    = RUN;
          w_set_err = 1'b1;
        end else begin
          w_next       = MD_BUSY;
          w_stall      = 1'b1;
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
      end
      default: begin
        // Branch wins: the ID instruction is on the wrong path, so any
        // hazard or mul/div it would raise is irrelevant.
        if (branch_taken_ex) begin
          w_flush = 1'b1;
        end else if (w_lu) begin
          w_stall = 1'b1;
          if (LU_MULTI) begin
            w_next       = LU_STALL;
            w_lu_cnt_nxt = LU_LOAD;
          end
        end else if (md_req_id) begin
          w_stall      = 1'b1;
          w_start      = 1'b1;
          w_to_cnt_nxt = 8'd0;
          w_next       = MD_BUSY;
        end
      end
    endcase
  end

  // Outputs are combinational but forced inactive while reset is held.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    md_start    = 1'b0;
    if (rst_n) begin
      pc_write    = !w_stall;
      ifid_write  = !w_stall;
      idex_bubble = w_stall || w_flush;
      ifid_flush  = w_flush;
      md_start    = w_start;
    end
  end

  assign md_error  = r_md_error;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_lu_cnt    <= 2'd0;
      r_to_cnt    <= 8'd0;
      r_md_error  <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state  <= w_next;
      r_lu_cnt <= w_lu_cnt_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      if (w_set_err) begin
        r_md_error <= 1'b1;
      end
      if (!pc_write && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Two instances share stimulus:
//   d0: LU_STALL_CYCLES=1, MD_TIMEOUT=255
//   d1: LU_STALL_CYCLES=3, MD_TIMEOUT=4
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] RsAddr_id, RtAddr_id, RegWriteAddr_ex;
  logic       MemRead_ex, branch_taken_ex, md_req_id, md_done;

  logic        a_pcw, a_ifw, a_bub, a_fl, a_st, a_err;
  logic [15:0] a_cnt;
  logic        b_pcw, b_ifw, b_bub, b_fl, b_st, b_err;
  logic [15:0] b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .MD_TIMEOUT(255)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
    .MemRead_ex(MemRead_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
    .branch_taken_ex(branch_taken_ex), .md_req_id(md_req_id), .md_done(md_done),
    .pc_write(a_pcw), .ifid_write(a_ifw), .idex_bubble(a_bub),
    .ifid_flush(a_fl), .md_start(a_st), .md_error(a_err), .stall_cnt(a_cnt)
  );

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .MD_TIMEOUT(4)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
    .MemRead_ex(MemRead_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
    .branch_taken_ex(branch_taken_ex), .md_req_id(md_req_id), .md_done(md_done),
    .pc_write(b_pcw), .ifid_write(b_ifw), .idex_bubble(b_bub),
    .ifid_flush(b_fl), .md_start(b_st), .md_error(b_err), .stall_cnt(b_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_outs(input string tag, input int d,
                             input logic pc, input logic ifw, input logic bub,
                             input logic fl, input logic st);
    chk($sformatf("%s/d%0d/pc_write", tag, d),    d == 0 ? a_pcw : b_pcw, pc);
    chk($sformatf("%s/d%0d/ifid_write", tag, d),  d == 0 ? a_ifw : b_ifw, ifw);
    chk($sformatf("%s/d%0d/idex_bubble", tag, d), d == 0 ? a_bub : b_bub, bub);
    chk($sformatf("%s/d%0d/ifid_flush", tag, d),  d == 0 ? a_fl  : b_fl,  fl);
    chk($sformatf("%s/d%0d/md_start", tag, d),    d == 0 ? a_st  : b_st,  st);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                       input logic [4:0] rwa, input logic br, input logic mq,
                       input logic mdn);
    RsAddr_id = rs; RtAddr_id = rt; MemRead_ex = mr; RegWriteAddr_ex = rwa;
    branch_taken_ex = br; md_req_id = mq; md_done = mdn;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks "stall cycles still owed", "waiting on mul/div" and wait count.
  int LUC[2] = '{1, 3};
  int TOL[2] = '{255, 4};
  int m_lu_left[2];
  bit m_md[2];
  int m_wait[2];
  bit m_err[2];
  int m_stalls[2];

  task automatic model_reset(input int d);
    m_lu_left[d] = 0; m_md[d] = 1'b0; m_wait[d] = 0; m_err[d] = 1'b0; m_stalls[d] = 0;
  endtask

  // Called at the falling edge: compares, then advances to the next edge.
  task automatic model_cmp(input int d);
    bit haz, stall, fl, st;
    if (!rst_n) model_reset(d);
    chk($sformatf("rand/d%0d/stall_cnt", d), d == 0 ? a_cnt : b_cnt, m_stalls[d]);
    chk($sformatf("rand/d%0d/md_error", d),  d == 0 ? a_err : b_err, m_err[d]);
    if (!rst_n) begin
      expect_outs("rand_rst", d, 0, 0, 0, 0, 0);
      return;
    end
    haz = MemRead_ex && RegWriteAddr_ex != 0 &&
          (RegWriteAddr_ex == RsAddr_id || RegWriteAddr_ex == RtAddr_id);
    stall = 0; fl = 0; st = 0;
    if (m_lu_left[d] > 0) begin
      stall = 1; m_lu_left[d]--;
    end else if (m_md[d]) begin
      if (md_done) m_md[d] = 0;
      else if (m_wait[d] == TOL[d]) begin m_md[d] = 0; m_err[d] = 1; end
      else begin stall = 1; m_wait[d]++; end
    end else if (branch_taken_ex) begin
      fl = 1;
    end else if (haz) begin
      stall = 1; m_lu_left[d] = LUC[d] - 1;
    end else if (md_req_id) begin
      stall = 1; st = 1; m_md[d] = 1; m_wait[d] = 0;
    end
    expect_outs("rand", d, !stall, !stall, stall | fl, fl, st);
    if (stall && m_stalls[d] < 65535) m_stalls[d]++;
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] rwa;
    logic       br, mq, mdn;
    logic       pc, ifw, bub, fl, st;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{5'd1, 5'd2, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // idle
    tbl[1]  = '{5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // lu on Rs
    tbl[2]  = '{5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // lu on Rt
    tbl[3]  = '{5'd4, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // r0 never hazards
    tbl[4]  = '{5'd5, 5'd2, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // match, not a load
    tbl[5]  = '{5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // branch
    tbl[6]  = '{5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // br+lu+md
    tbl[7]  = '{5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // lu beats md
    tbl[8]  = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // md launch
    tbl[9]  = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // stray md_done
    tbl[10] = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // br beats md
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: every output low even with all events requested.
    drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) expect_outs("reset", d, 0, 0, 0, 0, 0);
    chk("reset/d0/stall_cnt", a_cnt, 16'd0);
    chk("reset/d1/stall_cnt", b_cnt, 16'd0);
    chk("reset/d0/md_error", a_err, 1'b0);
    chk("reset/d1/md_error", b_err, 1'b0);

    // Table of single-cycle decodes from a freshly reset RUN state.
    foreach (tbl[i]) begin
      tick();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      drive(tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].rwa, tbl[i].br, tbl[i].mq, tbl[i].mdn);
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        expect_outs($sformatf("vec%0d", i), d, tbl[i].pc, tbl[i].ifw, tbl[i].bub, tbl[i].fl, tbl[i].st);
    end

    // Load-use: d0 stalls 1 cycle, d1 stalls 3 cycles total.
    tick(); rst_pulse();
    drive(5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) expect_outs("lu_c0", d, 0, 0, 1, 0, 0);
    tick(); idle();
    @(negedge clk);
    expect_outs("lu_c1", 0, 1, 1, 0, 0, 0);
    expect_outs("lu_c1", 1, 0, 0, 1, 0, 0);
    chk("lu/d0/stall_cnt", a_cnt, 16'd1);
    tick();
    @(negedge clk);
    expect_outs("lu_c2", 1, 0, 0, 1, 0, 0);
    tick();
    @(negedge clk);
    expect_outs("lu_c3", 1, 1, 1, 0, 0, 0);
    chk("lu/d1/stall_cnt", b_cnt, 16'd3);
    chk("lu/d0/stall_cnt_hold", a_cnt, 16'd1);

    // Mul/div: d0 waits 10 busy cycles then sees md_done; d1 times out at 4.
    tick(); rst_pulse();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) expect_outs("md_launch", d, 0, 0, 1, 0, 1);
    tick(); idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      expect_outs($sformatf("md_busy%0d", k), 0, 0, 0, 1, 0, 0);
      expect_outs($sformatf("md_to%0d", k), 1, k >= 4, k >= 4, k < 4, 0, 0);
      tick();
    end
    md_done = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) expect_outs("md_done", d, 1, 1, 0, 0, 0);
    tick(); idle();
    @(negedge clk);
    expect_outs("md_after", 0, 1, 1, 0, 0, 0);
    chk("md/d0/stall_cnt", a_cnt, 16'd11);
    chk("md/d0/md_error", a_err, 1'b0);
    chk("md/d1/md_error", b_err, 1'b1);
    chk("md/d1/stall_cnt", b_cnt, 16'd5);
    repeat (3) tick();
    chk("md/d1/md_error_sticky", b_err, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("md/d1/md_error_cleared", b_err, 1'b0);
    rst_n = 1'b1;

    // Reset in the middle of MD_BUSY aborts without a new launch.
    tick(); rst_pulse();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    tick(); rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) expect_outs("abort_rst", d, 0, 0, 0, 0, 0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) expect_outs("abort_run", d, 1, 1, 0, 0, 0);
    chk("abort/d0/stall_cnt", a_cnt, 16'd0);

    // Reset in the middle of LU_STALL on d1.
    tick();
    drive(5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    rst_pulse();
    @(negedge clk);
    expect_outs("lu_abort", 1, 1, 1, 0, 0, 0);

    // Randomized run against the reference model, with occasional resets.
    tick(); rst_pulse();
    model_reset(0); model_reset(1);
    for (int n = 0; n < 3000; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      model_cmp(0);
      model_cmp(1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, the total ID-stage stall cycles per load-use hazard (legal 1..4).
REQ-002 SHALL have parameter MD_TIMEOUT, default 255, the maximum MD_BUSY cycles before abort (legal 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 RsAddr_id, RtAddr_id  input  5 each  source register addresses of the ID instruction.
REQ-007 MemRead_ex  input  1  EX instruction is a load.
REQ-008 RegWriteAddr_ex  input  5  destination register of the EX instruction.
REQ-009 branch_taken_ex  input  1  EX resolved a taken branch or jump.
REQ-010 md_req_id  input  1  ID instruction is a multiply/divide.
REQ-011 md_done  input  1  one-cycle completion pulse from the mul/div unit.
REQ-012 pc_write, ifid_write  output  1 each  PC and IF/ID register enables.
REQ-013 idex_bubble  output  1  load a NOP into ID/EX.
REQ-014 ifid_flush  output  1  clear IF/ID.
REQ-015 md_start  output  1  one-cycle launch pulse to the mul/div unit.
REQ-016 md_error  output  1  sticky timeout flag.
REQ-017 stall_cnt  output  16  count of stalled cycles.

Function
REQ-018 SHALL implement four states: RUN=0, LU_STALL=1, MD_BUSY=2, and HOLD=3 (unused; decodes to RUN).
REQ-019 SHALL register only the state, the 2-bit stall counter, the 8-bit timeout counter, md_error and stall_cnt; all other outputs SHALL be combinational from state and inputs.
REQ-020 The hazard condition lu SHALL be MemRead_ex && RegWriteAddr_ex!=0 && (RegWriteAddr_ex==RsAddr_id || RegWriteAddr_ex==RtAddr_id).
REQ-021 In RUN with no event: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, md_start=0.
REQ-022 In RUN, events SHALL be prioritised branch_taken_ex > lu > md_req_id.
REQ-023 RUN and branch_taken_ex: ifid_flush=1 and idex_bubble=1; pc_write=1; state stays RUN.
REQ-024 RUN and lu: pc_write=0, ifid_write=0, idex_bubble=1; if LU_STALL_CYCLES>1, go to LU_STALL with the counter loaded to LU_STALL_CYCLES-2; otherwise stay in RUN.
REQ-025 LU_STALL: same stall outputs as REQ-024; the counter decrements each cycle; leave to RUN on the cycle the counter reads 0 (that cycle still stalls).
REQ-026 RUN and md_req_id: md_start=1 for exactly this cycle; stall outputs as REQ-024; timeout counter cleared; go to MD_BUSY.
REQ-027 MD_BUSY without md_done: stall outputs as REQ-024; the timeout counter increments.
REQ-028 MD_BUSY with md_done: pc_write=1, ifid_write=1, idex_bubble=0; go to RUN; md_start never reasserts for the same instruction.
REQ-029 MD_BUSY when the timeout counter reaches MD_TIMEOUT: set md_error and go to RUN, releasing as in REQ-028.
REQ-030 branch_taken_ex and md_done outside their qualifying states SHALL be ignored.
REQ-031 stall_cnt SHALL increment on every clock edge where pc_write==0, saturating at 16'hFFFF.
REQ-032 md_error SHALL clear only on reset.

Reset
REQ-033 While rst_n==0: state=RUN, counters=0, md_error=0, stall_cnt=0, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, md_start=0.
REQ-034 On the first edge after rst_n rises, behaviour SHALL follow RUN; reset asserted mid-MD_BUSY or mid-LU_STALL SHALL abort to RUN without issuing md_start.

Verification
REQ-035 LU_STALL_CYCLES=1: MemRead_ex=1, RegWriteAddr_ex=5, RsAddr_id=5 -> one cycle with pc_write=0 and idex_bubble=1; stall_cnt=1; next cycle pc_write=1.
REQ-036 LU_STALL_CYCLES=3: same stimulus with MemRead_ex dropping after 1 cycle -> exactly 3 stall cycles; stall_cnt=3.
REQ-037 RegWriteAddr_ex=0=RtAddr_id with MemRead_ex=1 -> no stall.
REQ-038 branch_taken_ex=1, lu=1, and md_req_id=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, md_start=0.
REQ-039 md_req_id=1, md_done arriving 10 cycles later -> md_start pulses once; 10 stall cycles plus the launch cycle; release on the md_done cycle.
REQ-040 MD_TIMEOUT=4 with no md_done -> md_error=1 after 4 MD_BUSY cycles, return to RUN; md_error persists until rst_n=0.
